// File: rtl/zcmt_pkg.sv
// -----------------------------------------------------------------------------
// zcmt_pkg
// Shared types for the ZCMT / LSU data-cache load-port arbiter.
//  - arb_state_e      : arbiter FSM states
//  - PORT_LSU/ZCMT    : port numbering used for owner / last-grant tracking
//  - arb_dcache_req_t : load request towards the data cache
//  - arb_dcache_rsp_t : load response from the data cache
// -----------------------------------------------------------------------------
package zcmt_pkg;

   localparam int XLEN               = 64;
   localparam int DCACHE_INDEX_WIDTH = 12;
   localparam int DCACHE_TAG_WIDTH   = 44;
   localparam int DCACHE_ID_WIDTH    = 2;

   localparam logic PORT_LSU  = 1'b0;
   localparam logic PORT_ZCMT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RSP,
      DRAIN
   } arb_state_e;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [XLEN-1:0]               data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [XLEN/8-1:0]             data_be;
      logic [1:0]                    data_size;
      logic [DCACHE_ID_WIDTH-1:0]    data_id;
      logic                          kill_req;
      logic                          tag_valid;
   } arb_dcache_req_t;

   typedef struct packed {
      logic                       data_gnt;
      logic                       data_rvalid;
      logic [DCACHE_ID_WIDTH-1:0] data_rid;
      logic [XLEN-1:0]            data_rdata;
   } arb_dcache_rsp_t;

endpackage

// File: rtl/zcmt_rr_pick2.sv
// -----------------------------------------------------------------------------
// zcmt_rr_pick2
// Combinational two-requester round-robin picker.
//  req_i[1:0] in  : request vector (bit 0 = LSU, bit 1 = ZCMT)
//  last_i     in  : port granted most recently
//  winner_o   out : selected port (only meaningful when valid_o)
//  valid_o    out : at least one request present
// -----------------------------------------------------------------------------
module zcmt_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       winner_o,
   output logic       valid_o
);

   assign valid_o  = |req_i;
   // With a single requester its index is simply req_i[1]; on a tie the port
   // that did not win last time goes first.
   assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/zcmt_dcache_arbiter.sv
// -----------------------------------------------------------------------------
// zcmt_dcache_arbiter
// Shares one data-cache load port between the LSU load path (port 0) and the
// ZCMT jump-table fetcher (port 1). Round-robin grant, one transaction in
// flight, owner locked from grant until response, flush draining and a
// response watchdog.
//
// Ports
//  clk_i        in  : clock
//  rst_ni       in  : asynchronous active-low reset
//  flush_i      in  : pipeline flush, abandons the current transaction
//  lsu_req_i    in  : LSU load request
//  lsu_rsp_o    out : LSU response (gnt/rvalid only when LSU owns the port)
//  zcmt_req_i   in  : ZCMT table-fetch request
//  zcmt_rsp_o   out : ZCMT response (gnt/rvalid only when ZCMT owns the port)
//  dcache_req_o out : muxed request to the data cache
//  dcache_rsp_i in  : data-cache response
//  busy_o       out : arbiter not idle
//  timeout_o    out : one-cycle pulse when the watchdog aborts a transaction
// -----------------------------------------------------------------------------
module zcmt_dcache_arbiter
   import zcmt_pkg::*;
#(
   parameter type         dcache_req_i_t = arb_dcache_req_t,
   parameter type         dcache_req_o_t = arb_dcache_rsp_t,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  dcache_req_i_t lsu_req_i,
   output dcache_req_o_t lsu_rsp_o,
   input  dcache_req_i_t zcmt_req_i,
   output dcache_req_o_t zcmt_rsp_o,
   output dcache_req_i_t dcache_req_o,
   input  dcache_req_o_t dcache_rsp_i,
   output logic          busy_o,
   output logic          timeout_o
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e                 state_q, state_d;
   logic                       owner_q, owner_d;
   logic                       last_q, last_d;
   logic [DCACHE_ID_WIDTH-1:0] id_q, id_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic [1:0]    pick_req;
   logic          pick_winner;
   logic          pick_valid;
   dcache_req_i_t win_req;
   dcache_req_i_t own_req;
   dcache_req_i_t req_mux;
   logic          route_port;
   logic          fwd_gnt;
   logic          fwd_rvalid;
   logic          wd_fire;
   logic          rsp_match;
   logic          wd_expired;
   logic [CNT_W-1:0] cnt_inc;

   assign pick_req = {zcmt_req_i.data_req, lsu_req_i.data_req};

   zcmt_rr_pick2 u_pick (
      .req_i    (pick_req),
      .last_i   (last_q),
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

   assign win_req    = (pick_winner == PORT_ZCMT) ? zcmt_req_i : lsu_req_i;
   assign own_req    = (owner_q == PORT_ZCMT) ? zcmt_req_i : lsu_req_i;
   assign rsp_match  = dcache_rsp_i.data_rvalid && (dcache_rsp_i.data_rid == id_q);
   assign wd_expired = (cnt_q == CNT_LAST);
   // Counter holds at its terminal value instead of wrapping.
   assign cnt_inc    = wd_expired ? cnt_q : cnt_q + 1'b1;

   // Next-state logic and request/response steering.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      req_mux    = '0;
      route_port = owner_q;
      fwd_gnt    = 1'b0;
      fwd_rvalid = 1'b0;
      wd_fire    = 1'b0;

      case (state_q)
         IDLE: begin
            // Stray rvalids (including ones outstanding across reset) are
            // ignored here simply by never looking at them.
            if (pick_valid) begin
               route_port = pick_winner;
               req_mux    = win_req;
               fwd_gnt    = dcache_rsp_i.data_gnt;
               owner_d    = pick_winner;
               last_d     = pick_winner;
               id_d       = win_req.data_id;
               cnt_d      = '0;
               state_d    = dcache_rsp_i.data_gnt ? WAIT_RSP : WAIT_GNT;
            end
         end

         WAIT_GNT: begin
            req_mux = own_req;
            if (flush_i || !own_req.data_req) begin
               req_mux.data_req = 1'b0;
               state_d          = IDLE;
            end else if (dcache_rsp_i.data_gnt) begin
               fwd_gnt = 1'b1;
               cnt_d   = '0;
               state_d = WAIT_RSP;
            end
         end

         WAIT_RSP: begin
            // Tag phase: keep the owner's tag fields flowing, never re-request.
            req_mux          = own_req;
            req_mux.data_req = 1'b0;
            cnt_d            = cnt_inc;
            if (rsp_match) begin
               fwd_rvalid = 1'b1;
               state_d    = IDLE;
            end else if (wd_expired) begin
               wd_fire = 1'b1;
               state_d = IDLE;
            end else if (flush_i) begin
               req_mux.kill_req = 1'b1;
               state_d          = DRAIN;
            end
         end

         DRAIN: begin
            // Response still owed by the cache; swallow it before re-arbitrating.
            cnt_d = cnt_inc;
            if (rsp_match) begin
               state_d = IDLE;
            end else if (wd_expired) begin
               wd_fire = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Output drive; everything is held at zero while reset is asserted.
   always_comb begin
      lsu_rsp_o    = '0;
      zcmt_rsp_o   = '0;
      dcache_req_o = '0;
      busy_o       = 1'b0;
      timeout_o    = 1'b0;
      if (rst_ni) begin
         dcache_req_o           = req_mux;
         busy_o                 = (state_q != IDLE);
         timeout_o              = wd_fire;
         lsu_rsp_o.data_rid     = dcache_rsp_i.data_rid;
         lsu_rsp_o.data_rdata   = dcache_rsp_i.data_rdata;
         zcmt_rsp_o.data_rid    = dcache_rsp_i.data_rid;
         zcmt_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
         if (route_port == PORT_ZCMT) begin
            zcmt_rsp_o.data_gnt    = fwd_gnt;
            zcmt_rsp_o.data_rvalid = fwd_rvalid;
         end else begin
            lsu_rsp_o.data_gnt    = fwd_gnt;
            lsu_rsp_o.data_rvalid = fwd_rvalid;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= PORT_LSU;
         last_q  <= PORT_ZCMT;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_zcmt_dcache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zcmt_dcache_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_zcmt_dcache_arbiter;
   import zcmt_pkg::*;

   localparam int T = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   arb_dcache_req_t lsu_req_i, zcmt_req_i, dcache_req_o;
   arb_dcache_rsp_t lsu_rsp_o, zcmt_rsp_o, dcache_rsp_i;
   logic            busy_o, timeout_o;

   always #5 clk_i = ~clk_i;

   zcmt_dcache_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .lsu_req_i    (lsu_req_i),
      .lsu_rsp_o    (lsu_rsp_o),
      .zcmt_req_i   (zcmt_req_i),
      .zcmt_rsp_o   (zcmt_rsp_o),
      .dcache_req_o (dcache_req_o),
      .dcache_rsp_i (dcache_rsp_i),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A transaction is "open" from selection until it completes; "accepted"
   // once the cache took the request; "dropped" once a flush abandoned it.
   bit         m_open, m_acc, m_drop, m_owner, m_last;
   logic [1:0] m_id;
   int         m_age;
   bit         n_open, n_acc, n_drop, n_owner, n_last;
   logic [1:0] n_id;
   int         n_age;

   arb_dcache_req_t e_req;
   arb_dcache_rsp_t e_lsu, e_zcmt;
   bit              e_busy, e_to;

   task automatic model_reset();
      m_open = 0; m_acc = 0; m_drop = 0; m_owner = 0; m_last = 1; m_id = '0; m_age = 0;
   endtask

   task automatic model_eval();
      arb_dcache_req_t oreq;
      bit port, gnt_p, rv_p, hit, timed;
      e_req = '0; e_lsu = '0; e_zcmt = '0; e_to = 0; e_busy = 0;
      gnt_p = 0; rv_p = 0; port = m_owner;
      n_open = m_open; n_acc = m_acc; n_drop = m_drop; n_owner = m_owner;
      n_last = m_last; n_id = m_id; n_age = m_age;
      if (rst_ni) begin
         e_busy = m_open;
         e_lsu.data_rid    = dcache_rsp_i.data_rid;
         e_lsu.data_rdata  = dcache_rsp_i.data_rdata;
         e_zcmt.data_rid   = dcache_rsp_i.data_rid;
         e_zcmt.data_rdata = dcache_rsp_i.data_rdata;
         hit   = dcache_rsp_i.data_rvalid && (dcache_rsp_i.data_rid == m_id);
         timed = (m_age == T - 1);
         oreq  = m_owner ? zcmt_req_i : lsu_req_i;
         if (!m_open) begin
            if (lsu_req_i.data_req || zcmt_req_i.data_req) begin
               if (lsu_req_i.data_req && zcmt_req_i.data_req) port = !m_last;
               else port = zcmt_req_i.data_req;
               oreq    = port ? zcmt_req_i : lsu_req_i;
               e_req   = oreq;
               gnt_p   = dcache_rsp_i.data_gnt;
               n_open  = 1; n_acc = gnt_p; n_drop = 0;
               n_owner = port; n_last = port; n_id = oreq.data_id; n_age = 0;
            end
         end else if (!m_acc) begin
            e_req = oreq;
            if (flush_i || !oreq.data_req) begin
               e_req.data_req = 1'b0;
               n_open = 0;
            end else if (dcache_rsp_i.data_gnt) begin
               gnt_p = 1; n_acc = 1; n_age = 0;
            end
         end else begin
            n_age = (m_age < T - 1) ? m_age + 1 : m_age;
            if (!m_drop) begin
               e_req = oreq;
               e_req.data_req = 1'b0;
               if (hit) begin rv_p = 1; n_open = 0; end
               else if (timed) begin e_to = 1; n_open = 0; end
               else if (flush_i) begin e_req.kill_req = 1'b1; n_drop = 1; end
            end else begin
               if (hit) n_open = 0;
               else if (timed) begin e_to = 1; n_open = 0; end
            end
         end
         if (port) begin e_zcmt.data_gnt = gnt_p; e_zcmt.data_rvalid = rv_p; end
         else begin e_lsu.data_gnt = gnt_p; e_lsu.data_rvalid = rv_p; end
      end
   endtask

   task automatic model_commit();
      m_open = n_open; m_owner = n_owner; m_last = n_last; m_id = n_id; m_age = n_age;
      m_acc  = n_open ? n_acc : 1'b0;
      m_drop = n_open ? n_drop : 1'b0;
   endtask

   // ---------------- cycle helpers ----------------
   task automatic sample();
      if (!rst_ni) model_reset();
      #2;
      model_eval();
      check("dcache_req", 256'(dcache_req_o), 256'(e_req));
      check("lsu_rsp", 256'(lsu_rsp_o), 256'(e_lsu));
      check("zcmt_rsp", 256'(zcmt_rsp_o), 256'(e_zcmt));
      check("busy", 256'(busy_o), 256'(e_busy));
      check("timeout", 256'(timeout_o), 256'(e_to));
   endtask

   task automatic advance();
      @(posedge clk_i);
      if (rst_ni) model_commit();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      lsu_req_i = '0; zcmt_req_i = '0; dcache_rsp_i = '0; flush_i = 1'b0;
   endtask

   task automatic reset_pulse();
      idle_inputs();
      rst_ni = 1'b0;
      sample(); advance();
      rst_ni = 1'b1;
   endtask

   task automatic rand_inputs();
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      lsu_req_i = r[$bits(arb_dcache_req_t)-1:0];
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      zcmt_req_i = r[$bits(arb_dcache_req_t)-1:0];
      lsu_req_i.data_req  = ($urandom_range(0, 3) != 0);
      zcmt_req_i.data_req = ($urandom_range(0, 3) != 0);
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      dcache_rsp_i = r[$bits(arb_dcache_rsp_t)-1:0];
      dcache_rsp_i.data_gnt    = $urandom_range(0, 1);
      dcache_rsp_i.data_rvalid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) dcache_rsp_i.data_rid = m_id;
      flush_i = ($urandom_range(0, 15) == 0);
   endtask

   // ---------------- stimulus ----------------
   int q_grant[$];
   int busy_cnt;
   int to_at;

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);

      // Reset: outputs zero regardless of inputs.
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         sample(); advance();
      end
      idle_inputs();
      rst_ni = 1'b1;

      // LSU alone, granted at once, response three cycles after the grant.
      lsu_req_i.data_req = 1'b1; lsu_req_i.data_id = 2'd2; lsu_req_i.address_tag = 44'h123;
      dcache_rsp_i.data_gnt = 1'b1;
      sample();
      check("t1_lsu_gnt", lsu_rsp_o.data_gnt, 1);
      check("t1_zcmt_gnt", zcmt_rsp_o.data_gnt, 0);
      advance();
      idle_inputs();
      busy_cnt = 0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 3) begin dcache_rsp_i.data_rvalid = 1'b1; dcache_rsp_i.data_rid = 2'd2; end
         else dcache_rsp_i = '0;
         sample();
         if (busy_o) busy_cnt++;
         check("t1_lsu_rvalid", lsu_rsp_o.data_rvalid, (i == 3));
         check("t1_zcmt_rvalid", zcmt_rsp_o.data_rvalid, 0);
         advance();
      end
      check("t1_busy_cycles", busy_cnt, 3);

      // Both request continuously: grants alternate starting with the LSU.
      reset_pulse();
      lsu_req_i.data_req = 1'b1;  lsu_req_i.data_id = 2'd1;
      zcmt_req_i.data_req = 1'b1; zcmt_req_i.data_id = 2'd2;
      for (int i = 0; i < 8; i++) begin
         dcache_rsp_i.data_gnt = 1'b1; dcache_rsp_i.data_rvalid = 1'b1; dcache_rsp_i.data_rid = m_id;
         sample();
         if (lsu_rsp_o.data_gnt) q_grant.push_back(0);
         if (zcmt_rsp_o.data_gnt) q_grant.push_back(1);
         advance();
      end
      check("t2_grants", q_grant.size(), 4);
      for (int k = 0; k < 4; k++)
         check("t2_order", (k < q_grant.size()) ? q_grant[k] : 9, k % 2);

      // ZCMT granted, flushed while waiting: kill pulse, response swallowed.
      reset_pulse();
      zcmt_req_i.data_req = 1'b1; zcmt_req_i.data_id = 2'd3; dcache_rsp_i.data_gnt = 1'b1;
      sample(); advance();
      idle_inputs(); flush_i = 1'b1;
      sample();
      check("t3_kill", dcache_req_o.kill_req, 1);
      advance();
      idle_inputs();
      sample(); check("t3_kill_once", dcache_req_o.kill_req, 0); advance();
      dcache_rsp_i.data_rvalid = 1'b1; dcache_rsp_i.data_rid = 2'd3;
      sample(); check("t3_zcmt_rvalid", zcmt_rsp_o.data_rvalid, 0); advance();
      idle_inputs();
      sample(); check("t3_idle", busy_o, 0); advance();

      // Watchdog: no response after the grant.
      reset_pulse();
      lsu_req_i.data_req = 1'b1; lsu_req_i.data_id = 2'd3; dcache_rsp_i.data_gnt = 1'b1;
      sample(); advance();
      idle_inputs();
      to_at = -1;
      for (int i = 1; i <= T; i++) begin
         sample();
         if (timeout_o && to_at < 0) to_at = i;
         advance();
      end
      check("t4_timeout_cycle", to_at, T);
      lsu_req_i.data_req = 1'b1; lsu_req_i.data_id = 2'd1; dcache_rsp_i.data_gnt = 1'b1;
      sample(); check("t4_regrant", lsu_rsp_o.data_gnt, 1); advance();

      // Reset while waiting; late response must be ignored.
      idle_inputs();
      sample(); advance();
      rst_ni = 1'b0;
      sample(); advance();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dcache_rsp_i.data_rvalid = 1'b1; dcache_rsp_i.data_rid = 2'd1;
         sample();
         check("t5_lsu_rvalid", lsu_rsp_o.data_rvalid, 0);
         check("t5_zcmt_rvalid", zcmt_rsp_o.data_rvalid, 0);
         advance();
      end

      // Mismatched id is held back, matching one delivered.
      reset_pulse();
      zcmt_req_i.data_req = 1'b1; zcmt_req_i.data_id = 2'd1; dcache_rsp_i.data_gnt = 1'b1;
      sample(); advance();
      idle_inputs();
      dcache_rsp_i.data_rvalid = 1'b1; dcache_rsp_i.data_rid = 2'd2;
      sample(); check("t6_wrong_id", zcmt_rsp_o.data_rvalid, 0); advance();
      dcache_rsp_i.data_rid = 2'd1;
      sample(); check("t6_right_id", zcmt_rsp_o.data_rvalid, 1); advance();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         rand_inputs();
         rst_ni = ($urandom_range(0, 199) != 0);
         sample(); advance();
      end
      rst_ni = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
